// File: rtl/alu_sched.sv
// Two-requester round-robin front end for alu_top: accepts one op at a time,
// waits out the ALU latency, and returns the captured result tagged with the requester ID.
module alu_sched #(
  parameter int unsigned OP_WIDTH  = 8,
  parameter int unsigned CMD_WIDTH = 4,
  parameter int unsigned LAT       = 3,
  parameter int unsigned MUL_LAT   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [1:0]             req_mode,
  input  logic [1:0]             req_cin,
  input  logic [3:0]             req_inp_valid,
  input  logic [2*CMD_WIDTH-1:0] req_cmd,
  input  logic [2*OP_WIDTH-1:0]  req_opa,
  input  logic [2*OP_WIDTH-1:0]  req_opb,
  output logic                   alu_ce,
  output logic                   alu_mode,
  output logic                   alu_cin,
  output logic [1:0]             alu_inp_valid,
  output logic [CMD_WIDTH-1:0]   alu_cmd,
  output logic [OP_WIDTH-1:0]    alu_opa,
  output logic [OP_WIDTH-1:0]    alu_opb,
  input  logic [2*OP_WIDTH-1:0]  alu_res,
  input  logic                   alu_cout,
  input  logic                   alu_oflow,
  input  logic                   alu_g,
  input  logic                   alu_l,
  input  logic                   alu_e,
  input  logic                   alu_err,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic                   rsp_id,
  output logic [2*OP_WIDTH-1:0]  rsp_res,
  output logic                   rsp_cout,
  output logic                   rsp_oflow,
  output logic                   rsp_g,
  output logic                   rsp_l,
  output logic                   rsp_e,
  output logic                   rsp_err,
  output logic [15:0]            op_count
);

  localparam int unsigned RES_W   = 2 * OP_WIDTH;
  localparam int unsigned MAX_LAT = (MUL_LAT > LAT) ? MUL_LAT : LAT;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);
  localparam logic [CMD_WIDTH-1:0] INC_MUL = CMD_WIDTH'(9);
  localparam logic [CMD_WIDTH-1:0] SHL_MUL = CMD_WIDTH'(10);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t               state_q, state_d;
  logic                 last_grant_q, last_grant_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 id_q, id_d;
  logic                 alu_ce_d, alu_mode_d, alu_cin_d;
  logic [1:0]           alu_inp_valid_d;
  logic [CMD_WIDTH-1:0] alu_cmd_d;
  logic [OP_WIDTH-1:0]  alu_opa_d, alu_opb_d;
  logic                 rsp_valid_d, rsp_id_d;
  logic [RES_W-1:0]     rsp_res_d;
  logic [5:0]           rsp_flags_q, rsp_flags_d;
  logic [15:0]          op_count_d;
  logic                 grant_id, accept, is_mul;

  // Lone requester wins; on a tie the one not granted last time wins.
  assign grant_id  = req_valid[1] & (~req_valid[0] | ~last_grant_q);
  assign req_ready = (rst && state_q == IDLE && |req_valid) ? (grant_id ? 2'b10 : 2'b01) : 2'b00;
  assign accept    = |(req_valid & req_ready);
  assign is_mul    = alu_mode && (alu_cmd == INC_MUL || alu_cmd == SHL_MUL);

  assign {rsp_cout, rsp_oflow, rsp_g, rsp_l, rsp_e, rsp_err} = rsp_flags_q;

  always_comb begin
    state_d         = state_q;
    last_grant_d    = last_grant_q;
    cnt_d           = cnt_q;
    id_d            = id_q;
    alu_ce_d        = alu_ce;
    alu_mode_d      = alu_mode;
    alu_cin_d       = alu_cin;
    alu_inp_valid_d = alu_inp_valid;
    alu_cmd_d       = alu_cmd;
    alu_opa_d       = alu_opa;
    alu_opb_d       = alu_opb;
    rsp_valid_d     = rsp_valid;
    rsp_id_d        = rsp_id;
    rsp_res_d       = rsp_res;
    rsp_flags_d     = rsp_flags_q;
    op_count_d      = op_count;
    case (state_q)
      IDLE: begin
        // The alu_* registers double as the single request latch.
        if (accept) begin
          id_d            = grant_id;
          last_grant_d    = grant_id;
          alu_ce_d        = 1'b1;
          alu_mode_d      = req_mode[grant_id];
          alu_cin_d       = req_cin[grant_id];
          alu_inp_valid_d = grant_id ? req_inp_valid[3:2] : req_inp_valid[1:0];
          alu_cmd_d       = grant_id ? req_cmd[2*CMD_WIDTH-1:CMD_WIDTH] : req_cmd[CMD_WIDTH-1:0];
          alu_opa_d       = grant_id ? req_opa[2*OP_WIDTH-1:OP_WIDTH] : req_opa[OP_WIDTH-1:0];
          alu_opb_d       = grant_id ? req_opb[2*OP_WIDTH-1:OP_WIDTH] : req_opb[OP_WIDTH-1:0];
          state_d         = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = is_mul ? CNT_W'(MUL_LAT) : CNT_W'(LAT);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d       = '0;
          alu_ce_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_id_d    = id_q;
          rsp_res_d   = alu_res;
          rsp_flags_d = {alu_cout, alu_oflow, alu_g, alu_l, alu_e, alu_err};
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (op_count != 16'hFFFF) op_count_d = op_count + 16'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      last_grant_q  <= 1'b1;
      cnt_q         <= '0;
      id_q          <= 1'b0;
      alu_ce        <= 1'b0;
      alu_mode      <= 1'b0;
      alu_cin       <= 1'b0;
      alu_inp_valid <= '0;
      alu_cmd       <= '0;
      alu_opa       <= '0;
      alu_opb       <= '0;
      rsp_valid     <= 1'b0;
      rsp_id        <= 1'b0;
      rsp_res       <= '0;
      rsp_flags_q   <= '0;
      op_count      <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      cnt_q         <= cnt_d;
      id_q          <= id_d;
      alu_ce        <= alu_ce_d;
      alu_mode      <= alu_mode_d;
      alu_cin       <= alu_cin_d;
      alu_inp_valid <= alu_inp_valid_d;
      alu_cmd       <= alu_cmd_d;
      alu_opa       <= alu_opa_d;
      alu_opb       <= alu_opb_d;
      rsp_valid     <= rsp_valid_d;
      rsp_id        <= rsp_id_d;
      rsp_res       <= rsp_res_d;
      rsp_flags_q   <= rsp_flags_d;
      op_count      <= op_count_d;
    end
  end

endmodule

// File: tb/tb_alu_sched.sv
// Directed bench for alu_sched with a small registered ALU model standing in for alu_top.
module tb_alu_sched;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  req_valid = '0, req_ready, req_mode = '0, req_cin = '0;
  logic [3:0]  req_inp_valid = '0;
  logic [7:0]  req_cmd = '0;
  logic [15:0] req_opa = '0, req_opb = '0;
  logic        alu_ce, alu_mode, alu_cin;
  logic [1:0]  alu_inp_valid;
  logic [3:0]  alu_cmd;
  logic [7:0]  alu_opa, alu_opb;
  logic [15:0] alu_res;
  logic        alu_cout, alu_oflow, alu_g, alu_l, alu_e, alu_err;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_id;
  logic [15:0] rsp_res, op_count;
  logic        rsp_cout, rsp_oflow, rsp_g, rsp_l, rsp_e, rsp_err;
  logic [21:0] alu_out = '0;
  int          total = 0, bad = 0, exp_cnt = 0;

  always #5 clk = ~clk;

  alu_sched dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_mode(req_mode), .req_cin(req_cin), .req_inp_valid(req_inp_valid),
    .req_cmd(req_cmd), .req_opa(req_opa), .req_opb(req_opb),
    .alu_ce(alu_ce), .alu_mode(alu_mode), .alu_cin(alu_cin), .alu_inp_valid(alu_inp_valid),
    .alu_cmd(alu_cmd), .alu_opa(alu_opa), .alu_opb(alu_opb), .alu_res(alu_res),
    .alu_cout(alu_cout), .alu_oflow(alu_oflow), .alu_g(alu_g), .alu_l(alu_l),
    .alu_e(alu_e), .alu_err(alu_err), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_res(rsp_res), .rsp_cout(rsp_cout), .rsp_oflow(rsp_oflow),
    .rsp_g(rsp_g), .rsp_l(rsp_l), .rsp_e(rsp_e), .rsp_err(rsp_err), .op_count(op_count)
  );

  // ALU stand-in: {err, cout, oflow, g, l, e, res}, registered while ce is high.
  function automatic logic [21:0] alu_f(input logic m, input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] r = '0;
    logic [4:0]  f = '0;
    logic        e = 1'b0;
    if (m) begin
      case (c)
        4'd0:    begin r = 16'(a) + 16'(b); f[4] = r[8]; end
        4'd1:    begin r = {8'h00, a - b}; f[3] = (a < b); end
        4'd9:    r = (16'(a) + 16'd1) * (16'(b) + 16'd1);
        4'd10:   r = (16'(a) << 1) * 16'(b);
        default: e = 1'b1;
      endcase
    end else begin
      case (c)
        4'd0:    r = {8'h00, a & b};
        4'd2:    r = {8'h00, a | b};
        default: e = 1'b1;
      endcase
    end
    return {e, f, r};
  endfunction

  always @(posedge clk) if (alu_ce) alu_out <= alu_f(alu_mode, alu_cmd, alu_opa, alu_opb);
  assign alu_res = alu_out[15:0];
  assign {alu_err, alu_cout, alu_oflow, alu_g, alu_l, alu_e} = alu_out[21:16];

  typedef struct {
    int          id;
    logic        mode;
    logic [3:0]  cmd;
    logic [7:0]  opa, opb;
    logic [15:0] res;
    logic        err;
    logic [4:0]  flags;
    int          lat;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input int id, input logic m, input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
    req_mode[id]              = m;
    req_cin[id]               = 1'b0;
    req_inp_valid[id*2 +: 2]  = 2'b11;
    req_cmd[id*4 +: 4]        = c;
    req_opa[id*8 +: 8]        = a;
    req_opb[id*8 +: 8]        = b;
  endtask

  task automatic wait_ready(input int id);
    #1;
    for (int k = 0; k < 30; k++) begin
      if (req_ready[id]) break;
      @(negedge clk);
    end
    check("ready_wait", 32'(req_ready[id]), 32'd1);
  endtask

  // Entered at the negedge of the ISSUE cycle; returns at the negedge where rsp_valid is first seen.
  task automatic collect(input int id, input logic [7:0] opa, input logic [15:0] res,
                         input logic err, input logic [4:0] flags, input int lat);
    int cyc = 0;
    check("issue_ce", 32'(alu_ce), 32'd1);
    check("issue_opa", 32'(alu_opa), 32'(opa));
    while (!rsp_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("latency", 32'(cyc), 32'(lat + 1));
    check("rsp_id", 32'(rsp_id), 32'(id));
    check("rsp_res", 32'(rsp_res), 32'(res));
    check("rsp_err", 32'(rsp_err), 32'(err));
    check("rsp_flags", 32'({rsp_cout, rsp_oflow, rsp_g, rsp_l, rsp_e}), 32'(flags));
    check("resp_ce", 32'(alu_ce), 32'd0);
  endtask

  task automatic complete();
    @(negedge clk);
    check("rsp_drop", 32'(rsp_valid), 32'd0);
    exp_cnt++;
    check("op_count", 32'(op_count), 32'(exp_cnt));
  endtask

  task automatic serve(input vec_t v);
    set_req(v.id, v.mode, v.cmd, v.opa, v.opb);
    req_valid[v.id] = 1'b1;
    wait_ready(v.id);
    @(negedge clk);
    req_valid[v.id] = 1'b0;
    collect(v.id, v.opa, v.res, v.err, v.flags, v.lat);
    complete();
  endtask

  task automatic tie_pair();
    set_req(0, 1'b0, 4'd0, 8'hF0, 8'h0F);
    set_req(1, 1'b0, 4'd2, 8'hF0, 8'h0F);
    req_valid = 2'b11;
    #1;
    check("tie_ready", 32'(req_ready), 32'h1);
    @(negedge clk);
    req_valid[0] = 1'b0;
    check("busy_ready", 32'(req_ready), 32'h0);
    collect(0, 8'hF0, 16'h0000, 1'b0, 5'b0, 3);
    complete();
    wait_ready(1);
    check("second_grant", 32'(req_ready), 32'h2);
    @(negedge clk);
    req_valid[1] = 1'b0;
    collect(1, 8'hF0, 16'h00FF, 1'b0, 5'b0, 3);
    complete();
  endtask

  initial begin
    logic seen;
    vecs[0] = '{0, 1'b1, 4'h0, 8'd10,  8'd20,  16'd30,   1'b0, 5'b00000, 3};
    vecs[1] = '{1, 1'b1, 4'h9, 8'd8,   8'd2,   16'd27,   1'b0, 5'b00000, 4};
    vecs[2] = '{0, 1'b1, 4'hF, 8'd1,   8'd1,   16'd0,    1'b1, 5'b00000, 3};
    vecs[3] = '{1, 1'b1, 4'hA, 8'd3,   8'd5,   16'd30,   1'b0, 5'b00000, 4};
    vecs[4] = '{0, 1'b0, 4'h9, 8'd1,   8'd1,   16'd0,    1'b1, 5'b00000, 3};
    vecs[5] = '{0, 1'b0, 4'h0, 8'hF0,  8'h3C,  16'h0030, 1'b0, 5'b00000, 3};
    vecs[6] = '{1, 1'b1, 4'h0, 8'd200, 8'd100, 16'd300,  1'b0, 5'b10000, 3};
    vecs[7] = '{1, 1'b1, 4'h1, 8'd25,  8'd10,  16'd15,   1'b0, 5'b00000, 3};

    // Reset state, with a request pending to show ready is held low.
    req_valid = 2'b01;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_ce", 32'(alu_ce), 32'h0);
    check("rst_op_count", 32'(op_count), 32'h0);
    req_valid = 2'b00;
    rst = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) serve(vecs[i]);

    // Last grant was req1, so req0 wins both ties.
    tie_pair();
    tie_pair();

    // Back-pressure: response held while a new req0 waits.
    rsp_ready = 1'b0;
    set_req(0, 1'b1, 4'd1, 8'd25, 8'd10);
    req_valid[0] = 1'b1;
    wait_ready(0);
    @(negedge clk);
    req_valid[0] = 1'b0;
    collect(0, 8'd25, 16'd15, 1'b0, 5'b0, 3);
    set_req(0, 1'b1, 4'd0, 8'd1, 8'd2);
    req_valid[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("stall_hold", 32'({rsp_valid, rsp_res, req_ready}), 32'({1'b1, 16'd15, 2'b00}));
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    complete();
    wait_ready(0);
    @(negedge clk);
    req_valid[0] = 1'b0;
    collect(0, 8'd1, 16'd3, 1'b0, 5'b0, 3);
    complete();

    // Reset in the middle of WAIT discards the op.
    set_req(0, 1'b1, 4'd0, 8'd10, 8'd20);
    req_valid[0] = 1'b1;
    wait_ready(0);
    @(negedge clk);
    req_valid[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_ce", 32'(alu_ce), 32'h0);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("midrst_op_count", 32'(op_count), 32'h0);
    check("midrst_opa", 32'(alu_opa), 32'h0);
    exp_cnt = 0;
    @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen = seen | rsp_valid;
    end
    check("lost_op_silent", 32'(seen), 32'h0);
    tie_pair();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
